instr_mem_loader: RTL
=====================

# instr_mem_loader

Boot-time program loader that writes the instruction memory the single-cycle CPU fetches from. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one write per word to sequential word-aligned addresses. It holds the CPU in reset until a load session completes, so the PC starts at address 0 on a freshly written program.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address bits; memory depth is 2^ADDR_WIDTH words.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle request to begin a load session; sampled only in IDLE.
- word_count_i  in  ADDR_WIDTH+1  number of words to load; latched on an accepted start_i.
- byte_valid_i  in  1  source has a byte on byte_data_i.
- byte_data_i  in  8  stream byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr_o  out  32  byte address of the write, word_index << 2, bits [1:0] = 0.
- mem_data_o  out  32  assembled instruction word.
- cpu_rst_o  out  1  holds the CPU in reset; high while not loaded or while loading.
- busy_o  out  1  session in progress.
- done_o  out  1  one-cycle pulse when the last word has been written.
- err_o  out  1  one-cycle pulse on a rejected start.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: byte_ready_o=0, busy_o=0. When start_i=1:
  - word_count_i=0 or word_count_i > 2^ADDR_WIDTH: pulse err_o, stay in IDLE, cpu_rst_o unchanged.
  - Otherwise latch the count, clear word_index and byte_index, set cpu_rst_o=1, and go to RECV.
- RECV: byte_ready_o=1, busy_o=1. A byte is accepted when byte_valid_i and byte_ready_o are both high.
  - The first accepted byte of a word goes into bits [31:24], then [23:16], [15:8] and [7:0].
  - On the 4th accepted byte, go to WRITE.
  - Stalls (byte_valid_i=0) of any length are allowed.
- WRITE: byte_ready_o=0. mem_we_o=1 for exactly this cycle, with mem_addr_o = word_index<<2 and mem_data_o = the assembled word. Then:
  - word_index+1 == count: go to DONE.
  - Otherwise increment word_index, clear byte_index, and return to RECV.
- DONE: pulse done_o, set cpu_rst_o=0, go to IDLE.
- start_i outside IDLE is ignored; it does not restart the session and does not raise err_o.
- word_index has ADDR_WIDTH+1 bits so it never wraps. With count = 2^ADDR_WIDTH, the last address is (2^ADDR_WIDTH - 1)<<2.
- mem_addr_o and mem_data_o hold their last written values outside WRITE.

## Timing
- All outputs are registered. The reset value of every output is 0, except cpu_rst_o = 1.
- Asserting rst_i at any time, including mid-word or mid-session, immediately forces IDLE and the reset values. A partial word is discarded and no write is issued. The next session starts at address 0.
- Latency with no stalls:
  - start_i accepted at edge N: byte_ready_o is high from cycle N+1.
  - 4th byte accepted at edge M: mem_we_o is high in cycle M+1.
  - byte_ready_o is high again in cycle M+2 (next word) or done_o is high in cycle M+2 (last word).
- Throughput: at most 5 cycles per word, 4 byte transfers plus 1 write cycle.
- cpu_rst_o falls in the same cycle done_o is high.

## Structure
- Shared package holds:
  - state encoding (IDLE, RECV, WRITE, DONE);
  - the BYTES_PER_WORD=4 constant;
  - the big-endian byte-lane shift amount (24 - 8*byte_index).
- Natural sub-module: word_assembler. It contains the 32-bit shift register and the 2-bit byte counter, takes an accept strobe and a clear, and outputs the word and a word_full flag.
- The FSM, word_index counter and output registers stay in instr_mem_loader.

## Test plan
- Reset: assert rst_i mid-cycle -> all outputs 0 immediately, cpu_rst_o=1; release -> IDLE, byte_ready_o=0.
- Two-word load, count=2, bytes 20 08 00 05 00 00 00 00 with no stalls -> first write addr 0x0 data 0x20080005, second write addr 0x4 data 0x00000000. done_o pulses 2 cycles after the 8th byte and cpu_rst_o falls with it.
- Backpressure: same stream with random byte_valid_i gaps of 0-7 cycles -> identical writes; exactly one mem_we_o per word; no byte lost or duplicated.
- Rejected start: word_count_i=0, then word_count_i=257 with ADDR_WIDTH=8 -> err_o pulses each time; no mem_we_o; busy_o stays 0.
- Reset mid-session: after 6 bytes of a 2-word load, assert rst_i -> no second write and cpu_rst_o=1. A new session with count=1 and bytes 8C 01 00 04 -> write addr 0x0 data 0x8C010004.
- Full depth: count=256 with ascending words; start_i pulsed during RECV -> last write at addr 0x3FC; start_i ignored; done_o pulses once.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared types and constants for the instruction memory loader
// Purpose: loader FSM state encoding, word geometry and big-endian lane helper.
// Ports: none (package).
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Bit offset of the lane a byte lands in: 24 - 8*idx. Written as 8*(3-idx)
  // so it stays a pure bit manipulation on the 2-bit index.
  function automatic logic [4:0] lane_shift(input logic [1:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// rtl/instr_mem_loader_word_assembler.sv - big-endian byte-to-word assembler
// Purpose: collects four accepted bytes MSB first into a 32-bit word.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      restart at byte lane 0 with an empty word
//   accept     a byte on data is taken this cycle
//   data       incoming byte
//   word       assembled word, including the byte being accepted this cycle
//   word_full  the accepted byte completes the word
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] shreg;
  logic [1:0]  byte_index;
  logic [4:0]  shift_amt;
  logic [31:0] merged;

  assign shift_amt = lane_shift(byte_index);
  // Replace only the target lane, so stale bytes of the previous word never leak.
  assign merged    = (shreg & ~(32'h0000_00FF << shift_amt)) | ({24'd0, data} << shift_amt);
  // Exposing the merged value lets the loader register the complete word on
  // the same edge the fourth byte is accepted.
  assign word      = accept ? merged : shreg;
  assign word_full = accept && (byte_index == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      byte_index <= '0;
    end else if (clear) begin
      shreg      <= '0;
      byte_index <= '0;
    end else if (accept) begin
      shreg      <= merged;
      byte_index <= byte_index + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot-time byte-stream loader for the instruction memory
// Purpose: receives a byte stream, builds big-endian words, writes them to
// sequential word addresses and holds the CPU in reset until loading ends.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             begin a session (sampled in IDLE only)
//   word_count_i        words to load, 1..2^ADDR_WIDTH
//   byte_valid_i/data_i byte stream in; byte_ready_o accepts
//   mem_we_o/addr_o/data_o  one write per word, byte address word_index<<2
//   cpu_rst_o           CPU reset hold; busy_o session active
//   done_o              pulse after last write; err_o pulse on rejected start
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state, state_n;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] word_index;

  logic ready_n, busy_n, we_n, done_n, err_n, cpu_rst_n;
  logic load_count, idx_clr, idx_inc, asm_clear;

  logic        accept;
  logic [31:0] asm_word;
  logic        word_full;

  assign accept = byte_valid_i && byte_ready_o;

  word_assembler u_word_assembler (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (asm_clear),
    .accept    (accept),
    .data      (byte_data_i),
    .word      (asm_word),
    .word_full (word_full)
  );

  // Next-state logic also computes the value each registered output takes
  // on entering the next state, so every output is a flop.
  always_comb begin
    state_n    = state;
    ready_n    = 1'b0;
    busy_n     = 1'b0;
    we_n       = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    cpu_rst_n  = cpu_rst_o;
    load_count = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    asm_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (word_count_i == '0 || word_count_i > MAX_COUNT) begin
            err_n = 1'b1;
          end else begin
            load_count = 1'b1;
            idx_clr    = 1'b1;
            asm_clear  = 1'b1;
            cpu_rst_n  = 1'b1;
            ready_n    = 1'b1;
            busy_n     = 1'b1;
            state_n    = RECV;
          end
        end
      end
      RECV: begin
        busy_n = 1'b1;
        if (word_full) begin
          we_n    = 1'b1;
          state_n = WRITE;
        end else begin
          ready_n = 1'b1;
        end
      end
      WRITE: begin
        if (word_index + IDX_ONE == count_q) begin
          done_n    = 1'b1;
          cpu_rst_n = 1'b0;
          state_n   = DONE;
        end else begin
          idx_inc = 1'b1;
          ready_n = 1'b1;
          busy_n  = 1'b1;
          state_n = RECV;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      word_index <= '0;
    end else begin
      if (load_count) count_q <= word_count_i;
      if (idx_clr) begin
        word_index <= '0;
      end else if (idx_inc) begin
        word_index <= word_index + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      cpu_rst_o    <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      byte_ready_o <= ready_n;
      mem_we_o     <= we_n;
      cpu_rst_o    <= cpu_rst_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
      err_o        <= err_n;
      // Address and data only move on a write, holding their last value otherwise.
      if (we_n) begin
        mem_addr_o <= 32'({word_index, 2'b00});
        mem_data_o <= asm_word;
      end
    end
  end

endmodule
